mem_bus_arbiter: RTL and testbench

//  Sequences the shared SoC memory bus (RAM 0x00000, MMIO 0x10000, ROM 0x20000) between three requesters:
//  - debug unit (dbg)
//  - CPU data bus (dbus)
//  - CPU instruction bus (ibus)

---
 rtl/mem_bus_arbiter_pkg.sv | 32 +++
 rtl/mem_bus_arbiter_if.sv | 66 ++++++
 rtl/mem_bus_arbiter_prio_pick.sv | 57 +++++
 rtl/mem_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM states, access owners and
// address-region decode on adr[17:16].
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DBG  = 2'd1,
    OWN_DBUS = 2'd2,
    OWN_IBUS = 2'd3
  } owner_t;

  localparam logic [1:0] REG_RAM  = 2'b00;
  localparam logic [1:0] REG_MMIO = 2'b01;
  localparam logic [1:0] REG_ROM  = 2'b10;
  localparam logic [1:0] REG_BAD  = 2'b11;

  // Request / grant bit positions used by the picker
  localparam int GNT_DBG  = 0;
  localparam int GNT_DBUS = 1;
  localparam int GNT_IBUS = 2;

  function automatic logic is_unmapped(input logic [1:0] region);
    return region == REG_BAD;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes and shared memory bus of the arbiter.
// slave = arbiter view, master = requesters plus bus slaves.
interface mem_bus_arbiter_if #(
  parameter int ADR_W  = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              cpu_run;

  logic              dbg_req;
  logic [ADR_W-1:0]  dbg_adr;
  logic [BE_W-1:0]   dbg_wren;
  logic [DATA_W-1:0] dbg_di;
  logic              dbg_ack;
  logic              dbg_rsp_valid;

  logic              dbus_req;
  logic [ADR_W-1:0]  dbus_adr;
  logic [BE_W-1:0]   dbus_wren;
  logic [DATA_W-1:0] dbus_di;
  logic              dbus_ack;
  logic              dbus_rsp_valid;
  logic              dbus_rsp_error;

  logic              ibus_req;
  logic [ADR_W-1:0]  ibus_adr;
  logic              ibus_ack;
  logic              ibus_rsp_valid;
  logic              ibus_rsp_error;

  logic [DATA_W-1:0] rsp_data;

  logic              m_op;
  logic [ADR_W-1:0]  m_adr;
  logic [BE_W-1:0]   m_wren;
  logic [DATA_W-1:0] m_di;
  logic [DATA_W-1:0] m_do;

  modport slave (
    input  cpu_run,
    input  dbg_req, dbg_adr, dbg_wren, dbg_di,
    output dbg_ack, dbg_rsp_valid,
    input  dbus_req, dbus_adr, dbus_wren, dbus_di,
    output dbus_ack, dbus_rsp_valid, dbus_rsp_error,
    input  ibus_req, ibus_adr,
    output ibus_ack, ibus_rsp_valid, ibus_rsp_error,
    output rsp_data,
    output m_op, m_adr, m_wren, m_di,
    input  m_do
  );

  modport master (
    output cpu_run,
    output dbg_req, dbg_adr, dbg_wren, dbg_di,
    input  dbg_ack, dbg_rsp_valid,
    output dbus_req, dbus_adr, dbus_wren, dbus_di,
    input  dbus_ack, dbus_rsp_valid, dbus_rsp_error,
    output ibus_req, ibus_adr,
    input  ibus_ack, ibus_rsp_valid, ibus_rsp_error,
    input  rsp_data,
    input  m_op, m_adr, m_wren, m_di,
    output m_do
  );

endinterface

// File: rtl/mem_bus_arbiter_prio_pick.sv
// arb_prio_pick: dbg > CPU one-hot picker. ARB_RR_EN selects round-robin
// between dbus and ibus; otherwise dbus always beats ibus.
module arb_prio_pick
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       advance,
  output logic [2:0] gnt
);

`ifdef ARB_RR_EN
  // Set when ibus was the last CPU port served; reset value lets dbus win first
  logic last_ibus;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_ibus <= 1'b1;
    end else if (advance) begin
      if (gnt[GNT_DBUS])
        last_ibus <= 1'b0;
      else if (gnt[GNT_IBUS])
        last_ibus <= 1'b1;
    end
  end

  always_comb begin
    gnt = '0;
    if (req[GNT_DBG])
      gnt[GNT_DBG] = 1'b1;
    else if (req[GNT_DBUS] && req[GNT_IBUS]) begin
      if (last_ibus)
        gnt[GNT_DBUS] = 1'b1;
      else
        gnt[GNT_IBUS] = 1'b1;
    end else if (req[GNT_DBUS])
      gnt[GNT_DBUS] = 1'b1;
    else if (req[GNT_IBUS])
      gnt[GNT_IBUS] = 1'b1;
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, reset, advance};

  always_comb begin
    gnt = '0;
    if (req[GNT_DBG])
      gnt[GNT_DBG] = 1'b1;
    else if (req[GNT_DBUS])
      gnt[GNT_DBUS] = 1'b1;
    else if (req[GNT_IBUS])
      gnt[GNT_IBUS] = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shared memory bus arbiter: dbg > CPU (dbus/ibus), one registered bus op per
// grant, IDLE -> BUS -> RESP. Optional macro ARB_RR_EN: dbus/ibus round-robin.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADR_W  = 32,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  state_t            state_q, state_d;
  owner_t            owner_q, sel_own;
  logic              err_q, zero_q;
  logic [2:0]        req, gnt;
  logic              win;
  logic [ADR_W-1:0]  sel_adr;
  logic [BE_W-1:0]   sel_wren;
  logic [DATA_W-1:0] sel_di;
  logic              sel_bad, sel_zero;

  logic              m_op_q;
  logic [ADR_W-1:0]  m_adr_q;
  logic [BE_W-1:0]   m_wren_q;
  logic [DATA_W-1:0] m_di_q;

  assign req = {bus.ibus_req & bus.cpu_run, bus.dbus_req & bus.cpu_run, bus.dbg_req};
  assign win = (state_q == IDLE) && (|gnt);

  arb_prio_pick u_pick (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (win),
    .gnt     (gnt)
  );

  always_comb begin
    sel_own  = OWN_NONE;
    sel_adr  = '0;
    sel_wren = '0;
    sel_di   = '0;
    if (gnt[GNT_DBG]) begin
      sel_own  = OWN_DBG;
      sel_adr  = bus.dbg_adr;
      sel_wren = bus.dbg_wren;
      sel_di   = bus.dbg_di;
    end else if (gnt[GNT_DBUS]) begin
      sel_own  = OWN_DBUS;
      sel_adr  = bus.dbus_adr;
      sel_wren = bus.dbus_wren;
      sel_di   = bus.dbus_di;
    end else if (gnt[GNT_IBUS]) begin
      sel_own  = OWN_IBUS;
      sel_adr  = bus.ibus_adr;
    end
  end

  // Only CPU accesses are errors; debug still drives the bus but nothing answers
  assign sel_zero = is_unmapped(sel_adr[17:16]);
  assign sel_bad  = sel_zero && (sel_own != OWN_DBG);

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win) state_d = BUS;
      BUS:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      zero_q   <= 1'b0;
      m_op_q   <= 1'b0;
      m_adr_q  <= '0;
      m_wren_q <= '0;
      m_di_q   <= '0;
    end else begin
      m_op_q <= 1'b0;
      if (win) begin
        owner_q  <= sel_own;
        err_q    <= sel_bad;
        zero_q   <= sel_zero;
        m_op_q   <= ~sel_bad;
        m_adr_q  <= sel_adr;
        m_wren_q <= sel_bad ? '0 : sel_wren;
        m_di_q   <= sel_di;
      end
    end
  end

  assign bus.m_op   = m_op_q;
  assign bus.m_adr  = m_adr_q;
  assign bus.m_wren = m_wren_q;
  assign bus.m_di   = m_di_q;

  assign bus.dbg_ack        = (state_q == BUS)  && (owner_q == OWN_DBG);
  assign bus.dbus_ack       = (state_q == BUS)  && (owner_q == OWN_DBUS);
  assign bus.ibus_ack       = (state_q == BUS)  && (owner_q == OWN_IBUS);
  assign bus.dbg_rsp_valid  = (state_q == RESP) && (owner_q == OWN_DBG);
  assign bus.dbus_rsp_valid = (state_q == RESP) && (owner_q == OWN_DBUS);
  assign bus.ibus_rsp_valid = (state_q == RESP) && (owner_q == OWN_IBUS);
  assign bus.dbus_rsp_error = bus.dbus_rsp_valid && err_q;
  assign bus.ibus_rsp_error = bus.ibus_rsp_valid && err_q;

  // Unmapped accesses and non-RESP cycles present 0 regardless of m_do
  assign bus.rsp_data = ((state_q == RESP) && !zero_q) ? bus.m_do : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small RAM-like bus slave model.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Bus slave: 256-word store, 1-cycle read latency, no slave at adr[17:16]==3
  logic [31:0] mem [0:255] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.m_op && bus.m_adr[17:16] != 2'b11) begin
      for (int b = 0; b < 4; b++)
        if (bus.m_wren[b]) mem[bus.m_adr[9:2]][8*b +: 8] <= bus.m_di[8*b +: 8];
      bus.m_do <= (bus.m_wren == 4'h0) ? mem[bus.m_adr[9:2]] : 32'h0;
    end else begin
      bus.m_do <= 32'h0;
    end
  end

  localparam logic [8:0] P_DBG_ACK  = 9'h100;
  localparam logic [8:0] P_DBG_RSP  = 9'h080;
  localparam logic [8:0] P_DBUS_ACK = 9'h040;
  localparam logic [8:0] P_DBUS_RSP = 9'h020;
  localparam logic [8:0] P_DBUS_ERR = 9'h010;
  localparam logic [8:0] P_IBUS_ACK = 9'h008;
  localparam logic [8:0] P_IBUS_RSP = 9'h004;
  localparam logic [8:0] P_IBUS_ERR = 9'h002;
  localparam logic [8:0] P_MOP      = 9'h001;

  function automatic logic [8:0] pulses();
    return {bus.dbg_ack, bus.dbg_rsp_valid, bus.dbus_ack, bus.dbus_rsp_valid,
            bus.dbus_rsp_error, bus.ibus_ack, bus.ibus_rsp_valid,
            bus.ibus_rsp_error, bus.m_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete debug access with checks on every cycle of it
  task automatic dbg_op(input string tag, input logic [31:0] adr, input logic [3:0] wren,
                        input logic [31:0] di, input logic [31:0] exp_rsp);
    bus.dbg_req = 1'b1; bus.dbg_adr = adr; bus.dbg_wren = wren; bus.dbg_di = di;
    tick();
    chk({tag, "_bus"}, 32'(pulses()), 32'(P_DBG_ACK | P_MOP));
    chk({tag, "_adr"}, bus.m_adr, adr);
    chk({tag, "_wren"}, 32'(bus.m_wren), 32'(wren));
    bus.dbg_req = 1'b0;
    tick();
    chk({tag, "_resp"}, 32'(pulses()), 32'(P_DBG_RSP));
    if (wren == 4'h0) chk({tag, "_data"}, bus.rsp_data, exp_rsp);
    tick();
    chk({tag, "_idle"}, 32'(pulses()), 32'h0);
  endtask

  logic [7:0] seq;
  int         n_gnt;

  initial begin
    reset = 1'b1;
    bus.cpu_run = 1'b0;
    bus.dbg_req = 1'b0;  bus.dbg_adr = '0;  bus.dbg_wren = '0;  bus.dbg_di = '0;
    bus.dbus_req = 1'b0; bus.dbus_adr = '0; bus.dbus_wren = '0; bus.dbus_di = '0;
    bus.ibus_req = 1'b0; bus.ibus_adr = '0;
    tick(); tick();
    chk("rst_pulses", 32'(pulses()), 32'h0);
    chk("rst_adr", bus.m_adr, 32'h0);
    chk("rst_wren", 32'(bus.m_wren), 32'h0);
    chk("rst_di", bus.m_di, 32'h0);
    chk("rst_data", bus.rsp_data, 32'h0);
    reset = 1'b0;
    bus.cpu_run = 1'b1;
    tick();

    // Debug write, readback, second word in ROM space
    dbg_op("t1_wr", 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0);
    chk("t1_hold_adr", bus.m_adr, 32'h0000_0010);
    dbg_op("t1_rd", 32'h0000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF);
    dbg_op("t1_wr2", 32'h0002_0004, 4'hF, 32'h1BAD_B002, 32'h0);

    // All three requesters rise together
    bus.dbg_req = 1'b1;  bus.dbg_adr = 32'h10; bus.dbg_wren = 4'h0;
    bus.dbus_req = 1'b1; bus.dbus_adr = 32'h10; bus.dbus_wren = 4'h0;
    bus.ibus_req = 1'b1; bus.ibus_adr = 32'h0002_0004;
    tick();
    chk("t2_dbg_ack", 32'(pulses()), 32'(P_DBG_ACK | P_MOP));
    bus.dbg_req = 1'b0;
    tick();
    chk("t2_dbg_rsp", 32'(pulses()), 32'(P_DBG_RSP));
    chk("t2_dbg_data", bus.rsp_data, 32'hDEAD_BEEF);
    tick();
    chk("t2_gap1", 32'(pulses()), 32'h0);
    tick();
    chk("t2_dbus_ack", 32'(pulses()), 32'(P_DBUS_ACK | P_MOP));
    bus.dbus_req = 1'b0;
    tick();
    chk("t2_dbus_rsp", 32'(pulses()), 32'(P_DBUS_RSP));
    chk("t2_dbus_data", bus.rsp_data, 32'hDEAD_BEEF);
    tick();
    chk("t2_gap2", 32'(pulses()), 32'h0);
    tick();
    chk("t2_ibus_ack", 32'(pulses()), 32'(P_IBUS_ACK | P_MOP));
    chk("t2_ibus_wren", 32'(bus.m_wren), 32'h0);
    bus.ibus_req = 1'b0;
    tick();
    chk("t2_ibus_rsp", 32'(pulses()), 32'(P_IBUS_RSP));
    chk("t2_ibus_data", bus.rsp_data, 32'h1BAD_B002);
    tick();
    chk("t2_idle", 32'(pulses()), 32'h0);

    // dbus and ibus both held for 12 cycles
    seq = '0;
    n_gnt = 0;
    bus.dbus_req = 1'b1; bus.ibus_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.dbus_ack) begin seq = {seq[5:0], 2'd1}; n_gnt++; end
      if (bus.ibus_ack) begin seq = {seq[5:0], 2'd2}; n_gnt++; end
    end
    bus.dbus_req = 1'b0; bus.ibus_req = 1'b0;
    chk("t3_count", 32'(n_gnt), 32'd4);
`ifdef ARB_RR_EN
    chk("t3_order", 32'(seq), 32'h66);
`else
    chk("t3_order", 32'(seq), 32'h55);
`endif
    tick();
    chk("t3_idle", 32'(pulses()), 32'h0);

    // Unmapped CPU accesses and a debug read of the unmapped region
    bus.ibus_req = 1'b1; bus.ibus_adr = 32'h0003_0000;
    tick();
    chk("t4_ibus_ack", 32'(pulses()), 32'(P_IBUS_ACK));
    bus.ibus_req = 1'b0;
    tick();
    chk("t4_ibus_err", 32'(pulses()), 32'(P_IBUS_RSP | P_IBUS_ERR));
    chk("t4_ibus_data", bus.rsp_data, 32'h0);
    tick();
    bus.dbus_req = 1'b1; bus.dbus_adr = 32'h0003_0040; bus.dbus_wren = 4'hF; bus.dbus_di = 32'hCAFE_F00D;
    tick();
    chk("t4_dbus_ack", 32'(pulses()), 32'(P_DBUS_ACK));
    chk("t4_dbus_wren", 32'(bus.m_wren), 32'h0);
    bus.dbus_req = 1'b0;
    tick();
    chk("t4_dbus_err", 32'(pulses()), 32'(P_DBUS_RSP | P_DBUS_ERR));
    tick();
    dbg_op("t4_dbg_bad", 32'h0003_0000, 4'h0, 32'h0, 32'h0);

    // CPU halted: no grant until cpu_run returns
    bus.cpu_run = 1'b0;
    bus.dbus_req = 1'b1; bus.dbus_adr = 32'h10; bus.dbus_wren = 4'h0;
    n_gnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pulses() != 9'h0) n_gnt++;
    end
    chk("t5_halted", 32'(n_gnt), 32'd0);
    bus.cpu_run = 1'b1;
    tick();
    chk("t5_ack", 32'(pulses()), 32'(P_DBUS_ACK | P_MOP));
    bus.dbus_req = 1'b0;
    tick();
    chk("t5_rsp", 32'(pulses()), 32'(P_DBUS_RSP));
    tick();

    // Reset while in BUS aborts the access
    bus.dbus_req = 1'b1; bus.dbus_adr = 32'h44; bus.dbus_wren = 4'hF; bus.dbus_di = 32'h1234_5678;
    tick();
    chk("t6_bus", 32'(pulses()), 32'(P_DBUS_ACK | P_MOP));
    reset = 1'b1;
    bus.dbus_req = 1'b0;
    tick();
    chk("t6_rst_pulses", 32'(pulses()), 32'h0);
    chk("t6_rst_adr", bus.m_adr, 32'h0);
    chk("t6_rst_wren", 32'(bus.m_wren), 32'h0);
    chk("t6_rst_di", bus.m_di, 32'h0);
    chk("t6_rst_data", bus.rsp_data, 32'h0);
    reset = 1'b0;
    tick();
    chk("t6_no_rsp", 32'(pulses()), 32'h0);
    tick();
    chk("t6_idle", 32'(pulses()), 32'h0);
    dbg_op("t6_recover", 32'h0000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
